// File: rtl/key_event_detector_if.sv
`default_nettype none
// ============================================================================
// Module   : key_event_detector_if
// Brief    : Debounced-key input pair and gesture-event outputs.
// Revision : 1.0 - initial release
// ============================================================================
interface key_event_detector_if;
  logic key_flag;
  logic key_value;
  logic short_press;
  logic double_press;
  logic long_press;
  logic long_hold;
  logic busy;

  modport master (
    output key_flag,
    output key_value,
    input  short_press,
    input  double_press,
    input  long_press,
    input  long_hold,
    input  busy
  );

  modport slave (
    input  key_flag,
    input  key_value,
    output short_press,
    output double_press,
    output long_press,
    output long_hold,
    output busy
  );
endinterface
`default_nettype wire

// File: rtl/key_event_detector.sv
`default_nettype none
// ============================================================================
// Module   : key_event_detector
// Brief    : Classifies debounced key gestures into short/double/long presses.
//            Optional macro KEY_EVT_REPEAT_EN adds long_press auto-repeat.
// Revision : 1.0 - initial release
// ============================================================================
module key_event_detector #(
  parameter int unsigned LONG_CYC    = 50_000_000,
  parameter int unsigned DBL_GAP_CYC = 12_500_000,
  parameter int unsigned REPEAT_CYC  = 10_000_000,
  parameter int unsigned CNT_W       = 26
) (
  input  wire logic              sys_clk,
  input  wire logic              sys_rst,
  key_event_detector_if.slave    bus
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_PRESS1 = 3'd1,
    ST_WAIT2  = 3'd2,
    ST_PRESS2 = 3'd3,
    ST_LONG   = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] C_LONG_LAST = CNT_W'(LONG_CYC - 1);
  localparam logic [CNT_W-1:0] C_GAP_LAST  = CNT_W'(DBL_GAP_CYC - 1);

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_short;
  logic             r_double;
  logic             r_long;
  logic             r_hold;
  logic             r_busy;

  logic w_press;
  logic w_release;

  assign w_press   = bus.key_flag & ~bus.key_value;
  assign w_release = bus.key_flag &  bus.key_value;

`ifdef KEY_EVT_REPEAT_EN
  localparam logic [CNT_W-1:0] C_RPT_LAST = CNT_W'(REPEAT_CYC - 1);
  logic [CNT_W-1:0] r_rpt_cnt;
`endif

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_short  <= 1'b0;
      r_double <= 1'b0;
      r_long   <= 1'b0;
      r_hold   <= 1'b0;
      r_busy   <= 1'b0;
`ifdef KEY_EVT_REPEAT_EN
      r_rpt_cnt <= '0;
`endif
    end else begin
      r_short  <= 1'b0;
      r_double <= 1'b0;
      r_long   <= 1'b0;
      // Saturate so a very long hold in PRESS2 never wraps into a false match.
      if (r_cnt != '1) r_cnt <= r_cnt + 1'b1;

      case (r_state)
        ST_IDLE: begin
          if (w_press) begin
            r_state <= ST_PRESS1;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
          end
        end
        ST_PRESS1: begin
          if (w_release) begin
            r_state <= ST_WAIT2;
            r_cnt   <= '0;
          end else if (r_cnt == C_LONG_LAST) begin
            r_state <= ST_LONG;
            r_cnt   <= '0;
            r_long  <= 1'b1;
            r_hold  <= 1'b1;
`ifdef KEY_EVT_REPEAT_EN
            r_rpt_cnt <= '0;
`endif
          end
        end
        ST_WAIT2: begin
          if (w_press) begin
            r_state <= ST_PRESS2;
            r_cnt   <= '0;
          end else if (r_cnt == C_GAP_LAST) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_short <= 1'b1;
            r_busy  <= 1'b0;
          end
        end
        ST_PRESS2: begin
          if (w_release) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_double <= 1'b1;
            r_busy   <= 1'b0;
          end
        end
        ST_LONG: begin
          if (w_release) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_hold  <= 1'b0;
            r_busy  <= 1'b0;
          end
`ifdef KEY_EVT_REPEAT_EN
          else if (r_rpt_cnt == C_RPT_LAST) begin
            r_long    <= 1'b1;
            r_rpt_cnt <= '0;
          end else begin
            r_rpt_cnt <= r_rpt_cnt + 1'b1;
          end
`endif
        end
        default: begin
          r_state <= ST_IDLE;
          r_cnt   <= '0;
          r_hold  <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.short_press  = r_short;
  assign bus.double_press = r_double;
  assign bus.long_press   = r_long;
  assign bus.long_hold    = r_hold;
  assign bus.busy         = r_busy;

endmodule
`default_nettype wire
